uart_rx: RTL and testbench

Tick-driven UART receiver. Consumes the one-cycle 16x-oversampling tick from the baud-rate generator, synchronizes the asynchronous serial line, and frames start, data, optional parity and stop bits. Delivers each received byte with a one-cycle done strobe and error flags. Sits between the RX pin and the UART interface/FIFO logic.

---
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Tick-driven UART receiver: 2-flop input synchronizer, 16x oversampled framing, done strobe + error flags.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_parity_err
);

  localparam int S_W = ($clog2(STOP_TICKS) > 4) ? $clog2(STOP_TICKS) : 4;
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [S_W-1:0] S_MID  = S_W'(7);
  localparam logic [S_W-1:0] S_BIT  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic                 r_rxMeta;
  logic                 r_rxSync;
  logic [S_W-1:0]       r_s;
  logic [S_W-1:0]       w_sNext;
  logic [N_W-1:0]       r_n;
  logic [N_W-1:0]       w_nNext;
  logic [DATA_BITS-1:0] r_b;
  logic [DATA_BITS-1:0] w_bNext;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_dataNext;
  logic                 r_done;
  logic                 w_doneNext;
  logic                 r_frameErr;
  logic                 w_frameErrNext;
`ifdef UART_RX_PARITY_EN
  logic                 r_parityBit;
  logic                 w_parityBitNext;
  logic                 r_parityErr;
  logic                 w_parityErrNext;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (!r_rxSync) w_stateNext = ST_START;
      ST_START: if (i_tick && r_s == S_MID) w_stateNext = r_rxSync ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (i_tick && r_s == S_BIT && r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
          w_stateNext = ST_PARITY;
`else
          w_stateNext = ST_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (i_tick && r_s == S_BIT) w_stateNext = ST_STOP;
`endif
      ST_STOP:  if (i_tick && r_s == S_STOP) w_stateNext = r_rxSync ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (r_rxSync) w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sNext        = r_s;
    w_nNext        = r_n;
    w_bNext        = r_b;
    w_dataNext     = r_data;
    w_doneNext     = 1'b0;
    w_frameErrNext = r_frameErr;
`ifdef UART_RX_PARITY_EN
    w_parityBitNext = r_parityBit;
    w_parityErrNext = r_parityErr;
`endif
    case (r_state)
      ST_IDLE: if (!r_rxSync) w_sNext = '0;
      ST_START:
        if (i_tick) begin
          if (r_s == S_MID) begin
            w_sNext = '0;
            w_nNext = '0;
          end else begin
            w_sNext = r_s + S_W'(1);
          end
        end
      ST_DATA:
        if (i_tick) begin
          if (r_s == S_BIT) begin
            w_bNext = {r_rxSync, r_b[DATA_BITS-1:1]};
            w_sNext = '0;
            if (r_n != N_LAST) w_nNext = r_n + N_W'(1);
          end else begin
            w_sNext = r_s + S_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
      ST_PARITY:
        if (i_tick) begin
          if (r_s == S_BIT) begin
            w_parityBitNext = r_rxSync;
            w_sNext         = '0;
          end else begin
            w_sNext = r_s + S_W'(1);
          end
        end
`endif
      // Stop sample publishes the word; flags only ever change alongside the strobe.
      ST_STOP:
        if (i_tick) begin
          if (r_s == S_STOP) begin
            w_sNext        = '0;
            w_doneNext     = 1'b1;
            w_dataNext     = r_b;
            w_frameErrNext = ~r_rxSync;
`ifdef UART_RX_PARITY_EN
            w_parityErrNext = (^r_b) ^ r_parityBit;
`endif
          end else begin
            w_sNext = r_s + S_W'(1);
          end
        end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rxMeta   <= 1'b1;
      r_rxSync   <= 1'b1;
      r_s        <= '0;
      r_n        <= '0;
      r_b        <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityBit <= 1'b0;
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_rxMeta   <= i_rx;
      r_rxSync   <= r_rxMeta;
      r_s        <= w_sNext;
      r_n        <= w_nNext;
      r_b        <= w_bNext;
      r_data     <= w_dataNext;
      r_done     <= w_doneNext;
      r_frameErr <= w_frameErrNext;
`ifdef UART_RX_PARITY_EN
      r_parityBit <= w_parityBitNext;
      r_parityErr <= w_parityErrNext;
`endif
    end
  end

  assign o_data      = r_data;
  assign o_rx_done   = r_done;
  assign o_frame_err = r_frameErr;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_parityErr;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed and random serial frames, expectations queued at send time.
// Honours UART_RX_PARITY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int STOP_TICKS = 16;
  localparam int BIT_TICKS  = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       rxDone;
  logic       frameErr;
  logic       parityErr;

  typedef struct {
    logic [7:0] data;
    logic       frameErr;
    logic       parityErr;
  } expect_t;

  expect_t expQ[$];
  int      compared   = 0;
  int      mismatched = 0;
  int      tickDiv    = 4;
  int      tickCnt    = 0;
  logic    prevDone   = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic    prevFerr   = 1'b0;
  logic    prevPerr   = 1'b0;

  uart_rx #(.DATA_BITS(DATA_BITS), .STOP_TICKS(STOP_TICKS)) dut (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_tick      (tick),
    .i_rx        (rx),
    .o_data      (data),
    .o_rx_done   (rxDone),
    .o_frame_err (frameErr),
    .o_parity_err(parityErr)
  );

  always #5 clock = ~clock;

  // Tick generator: one-clock pulse every tickDiv clocks; tickDiv == 1 holds it high.
  initial begin
    forever begin
      @(negedge clock);
      tickCnt++;
      if (tickCnt >= tickDiv) begin
        tick    = 1'b1;
        tickCnt = 0;
      end else begin
        tick = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic driveLevel(input logic level, input int ticks);
    rx = level;
    repeat (ticks * tickDiv) @(negedge clock);
  endtask

  // Sends one frame; abortBit in 0..7 pulses reset midway through that data bit instead.
  task automatic applyStimulus(input logic [7:0] value, input logic stopBit, input logic parityBit,
                               input int abortBit);
    expect_t e;
    if (abortBit < 0) begin
      e.data     = value;
      e.frameErr = ~stopBit;
`ifdef UART_RX_PARITY_EN
      e.parityErr = ^{value, parityBit};
`else
      e.parityErr = 1'b0;
`endif
      expQ.push_back(e);
    end
    driveLevel(1'b0, BIT_TICKS);
    for (int i = 0; i < 8; i++) begin
      if (i == abortBit) begin
        driveLevel(value[i], BIT_TICKS / 2);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("rst_data", {24'h0, data}, 32'h0);
        checkOutput("rst_done", {31'h0, rxDone}, 32'h0);
        checkOutput("rst_ferr", {31'h0, frameErr}, 32'h0);
        checkOutput("rst_perr", {31'h0, parityErr}, 32'h0);
        reset = 1'b0;
        return;
      end
      driveLevel(value[i], BIT_TICKS);
    end
`ifdef UART_RX_PARITY_EN
    driveLevel(parityBit, BIT_TICKS);
`endif
    driveLevel(stopBit, STOP_TICKS);
  endtask

  function automatic logic evenParity(input logic [7:0] v);
    return ^v;
  endfunction

  // Monitor: pops one expectation per strobe and watches that outputs hold between strobes.
  initial begin
    expect_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prevDone = 1'b0;
      end else if (rxDone) begin
        if (prevDone) checkOutput("done_width", {31'h0, prevDone}, 32'h0);
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_strobe: got data 0x%0h, expected no strobe at %0t", data, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("data", {24'h0, data}, {24'h0, e.data});
          checkOutput("frame_err", {31'h0, frameErr}, {31'h0, e.frameErr});
          checkOutput("parity_err", {31'h0, parityErr}, {31'h0, e.parityErr});
        end
      end else begin
        if (data !== prevData) checkOutput("data_hold", {24'h0, data}, {24'h0, prevData});
        if (frameErr !== prevFerr) checkOutput("ferr_hold", {31'h0, frameErr}, {31'h0, prevFerr});
        if (parityErr !== prevPerr) checkOutput("perr_hold", {31'h0, parityErr}, {31'h0, prevPerr});
      end
      prevDone = rxDone;
      prevData = data;
      prevFerr = frameErr;
      prevPerr = parityErr;
    end
  end

  initial begin
    #2_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] v;
    logic       stopBit;
    logic       parityBit;
    int         gap;

    repeat (5) @(negedge clock);
    checkOutput("reset_data", {24'h0, data}, 32'h0);
    checkOutput("reset_done", {31'h0, rxDone}, 32'h0);
    checkOutput("reset_ferr", {31'h0, frameErr}, 32'h0);
    checkOutput("reset_perr", {31'h0, parityErr}, 32'h0);
    reset = 1'b0;
    driveLevel(1'b1, 2 * BIT_TICKS);

    $display("[TB] directed frames");
    applyStimulus(8'hA5, 1'b1, evenParity(8'hA5), -1);
    driveLevel(1'b1, BIT_TICKS);

    driveLevel(1'b0, 4);
    driveLevel(1'b1, 2 * BIT_TICKS);
    applyStimulus(8'h3C, 1'b1, evenParity(8'h3C), -1);
    driveLevel(1'b1, BIT_TICKS);

    applyStimulus(8'h81, 1'b0, evenParity(8'h81), -1);
    driveLevel(1'b0, 40);
    driveLevel(1'b1, 2 * BIT_TICKS);
    applyStimulus(8'h42, 1'b1, evenParity(8'h42), -1);
    driveLevel(1'b1, BIT_TICKS);

    applyStimulus(8'h00, 1'b1, evenParity(8'h00), -1);
    applyStimulus(8'hFF, 1'b1, evenParity(8'hFF), -1);
    driveLevel(1'b1, BIT_TICKS);

    applyStimulus(8'h77, 1'b1, 1'b0, 4);
    driveLevel(1'b1, 2 * BIT_TICKS);
    applyStimulus(8'h5A, 1'b1, evenParity(8'h5A), -1);
    driveLevel(1'b1, BIT_TICKS);

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h03, 1'b1, 1'b1, -1);
    driveLevel(1'b1, BIT_TICKS);
    applyStimulus(8'h03, 1'b1, 1'b0, -1);
    driveLevel(1'b1, BIT_TICKS);
`endif

    $display("[TB] random frames");
    for (int f = 0; f < 30; f++) begin
      if (f % 8 == 0) begin
        driveLevel(1'b1, 2 * BIT_TICKS);
        tickDiv = $urandom_range(1, 4);
      end
      v         = 8'($urandom_range(0, 255));
      stopBit   = ($urandom_range(0, 5) != 0);
      parityBit = ($urandom_range(0, 3) == 0) ? ~evenParity(v) : evenParity(v);
      applyStimulus(v, stopBit, parityBit, -1);
      gap = stopBit ? $urandom_range(0, 2) : $urandom_range(1, 2);
      if (gap > 0) driveLevel(1'b1, gap * BIT_TICKS);
    end

    driveLevel(1'b1, 3 * BIT_TICKS);
    checkOutput("queue_empty", expQ.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
